// File: rtl/prism_aux_engine_if.sv
// ---------------------------------------------------------------------------
// prism_aux_engine_if
//   Bundles the FSM strobe/condition signals and the register bus that connect
//   the PRISM state machine and the TinyQV bus to prism_aux_engine.
//
//   master : PRISM FSM + register bus side (drives strobes and writes)
//   slave  : prism_aux_engine side (returns read data and condition flags)
//
//   Signals
//     exec        FSM running; strobes are ignored while low
//     cnt_load    per-channel load-from-preload strobe
//     cnt_dec     per-channel decrement strobe
//     evt_inc     event counter increment strobe
//     evt_clr     event counter clear strobe
//     shift       shift strobe
//     shift_in    serial data into the shift register
//     reg_addr    register word index
//     reg_wr      32-bit register write strobe
//     reg_wdata   register write data
//     reg_rdata   register read data (combinational from reg_addr)
//     cnt_zero    per-channel count == 0
//     evt_match   event count == compare
//     shift_done  shift bit counter == 0
//     shift_out   serial data out
//     irq         masked OR of sticky status flags
// ---------------------------------------------------------------------------
interface prism_aux_engine_if #(
    parameter int NCH = 2
);
    logic            exec;
    logic [NCH-1:0]  cnt_load;
    logic [NCH-1:0]  cnt_dec;
    logic            evt_inc;
    logic            evt_clr;
    logic            shift;
    logic            shift_in;
    logic [2:0]      reg_addr;
    logic            reg_wr;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;
    logic [NCH-1:0]  cnt_zero;
    logic            evt_match;
    logic            shift_done;
    logic            shift_out;
    logic            irq;

    modport master (
        output exec, cnt_load, cnt_dec, evt_inc, evt_clr, shift, shift_in,
               reg_addr, reg_wr, reg_wdata,
        input  reg_rdata, cnt_zero, evt_match, shift_done, shift_out, irq
    );

    modport slave (
        input  exec, cnt_load, cnt_dec, evt_inc, evt_clr, shift, shift_in,
               reg_addr, reg_wr, reg_wdata,
        output reg_rdata, cnt_zero, evt_match, shift_done, shift_out, irq
    );
endinterface

// File: rtl/prism_aux_engine.sv
// ---------------------------------------------------------------------------
// prism_aux_engine
//   Counter/shifter co-processor for the PRISM state machine peripheral:
//   NCH countdown channels with optional auto-reload, an event counter with
//   compare, a configurable-length bidirectional shift register and sticky
//   write-1-to-clear status flags with a maskable interrupt.
//
//   Ports
//     clk   single clock
//     rst   synchronous active-high reset
//     bus   prism_aux_engine_if.slave: FSM strobes, register bus, flags
//
//   Register map (reg_addr)
//     0 CTRL   [0] dir, [12:8] len-1, [16+:NCH] auto-reload, [26:24] irq en
//     1 STATUS [NCH-1:0] terminal, [8] match, [9] done (W1C)
//     2 SHIFT  shift register, zero-extended
//     3 EVT    write: compare; read: {count[15:8], compare[7:0]}
//     4+ch     write: preload; read: current count
// ---------------------------------------------------------------------------
module prism_aux_engine #(
    parameter int CNT_W = 24,
    parameter int NCH   = 2,
    parameter int SH_W  = 32,
    parameter int EVT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    prism_aux_engine_if.slave       bus
);

    // Control register fields
    logic             dir_q, dir_d;
    logic [4:0]       len_m1_q, len_m1_d;
    logic [NCH-1:0]   arl_q, arl_d;
    logic [2:0]       ien_q, ien_d;      // [0] zero, [1] match, [2] done

    // Countdown channels
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][CNT_W-1:0] pre_q, pre_d;

    // Event counter
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [EVT_W-1:0] cmp_q, cmp_d;
    logic [EVT_W-1:0] evt_nxt;

    // Shifter
    logic [SH_W-1:0]  sr_q, sr_d;
    logic [SH_W-1:0]  sr_shr;
    logic [4:0]       bcnt_q, bcnt_d;
    logic [5:0]       len_p1;

    // Sticky status
    logic [NCH-1:0]   sts_ch_q, sts_ch_d;
    logic             sts_match_q, sts_match_d;
    logic             sts_done_q, sts_done_d;

    // Decodes and per-cycle events
    logic             wr_ctrl, wr_sts, wr_shift, wr_evt;
    logic [NCH-1:0]   wr_pre;
    logic [NCH-1:0]   ld, dc;
    logic             inc, clr, sh;
    logic [NCH-1:0]   ch_set;
    logic             match_set, done_set;
    logic [NCH-1:0]   sts_clr;
    logic [31:0]      rdata;

    assign wr_ctrl  = bus.reg_wr && (bus.reg_addr == 3'd0);
    assign wr_sts   = bus.reg_wr && (bus.reg_addr == 3'd1);
    assign wr_shift = bus.reg_wr && (bus.reg_addr == 3'd2);
    assign wr_evt   = bus.reg_wr && (bus.reg_addr == 3'd3);

    always_comb begin
        wr_pre = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            wr_pre[ch] = bus.reg_wr && (bus.reg_addr == 3'(4 + ch));
        end
    end

    // All FSM strobes are gated by exec; register writes are not.
    assign ld  = bus.exec ? bus.cnt_load : '0;
    assign dc  = bus.exec ? bus.cnt_dec  : '0;
    assign inc = bus.exec && bus.evt_inc;
    assign clr = bus.exec && bus.evt_clr;
    assign sh  = bus.exec && bus.shift;

    assign len_p1  = {1'b0, len_m1_q} + 6'd1;
    assign evt_nxt = evt_q + 1'b1;
    assign sr_shr  = sr_q >> 1;

    // Control register: the length is clamped on write so the stored value is
    // always a legal bit index into the shift register.
    always_comb begin
        dir_d    = dir_q;
        len_m1_d = len_m1_q;
        arl_d    = arl_q;
        ien_d    = ien_q;
        if (wr_ctrl) begin
            dir_d    = bus.reg_wdata[0];
            len_m1_d = (bus.reg_wdata[12:8] > 5'(SH_W - 1)) ? 5'(SH_W - 1)
                                                            : bus.reg_wdata[12:8];
            arl_d    = bus.reg_wdata[16 +: NCH];
            ien_d    = bus.reg_wdata[26:24];
        end
    end

    // Countdown channels: load beats dec; the terminal step (1 -> 0 or reload)
    // raises the sticky flag, a dec at 0 does nothing.
    always_comb begin
        ch_set = '0;
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        for (int ch = 0; ch < NCH; ch++) begin
            if (wr_pre[ch]) begin
                pre_d[ch] = bus.reg_wdata[CNT_W-1:0];
            end
            if (ld[ch]) begin
                cnt_d[ch] = pre_q[ch];
            end else if (dc[ch]) begin
                if (cnt_q[ch] == CNT_W'(1)) begin
                    ch_set[ch] = 1'b1;
                    cnt_d[ch]  = arl_q[ch] ? pre_q[ch] : '0;
                end else if (cnt_q[ch] != '0) begin
                    cnt_d[ch] = cnt_q[ch] - 1'b1;
                end
            end
        end
    end

    // Event counter: inc+clr together is a software event that only flags.
    always_comb begin
        evt_d     = evt_q;
        cmp_d     = wr_evt ? bus.reg_wdata[EVT_W-1:0] : cmp_q;
        match_set = 1'b0;
        if (inc && clr) begin
            match_set = 1'b1;
        end else if (inc) begin
            evt_d     = evt_nxt;
            match_set = (evt_nxt == cmp_q);
        end else if (clr) begin
            evt_d = '0;
        end
    end

    // Shifter: a SHIFT write wins over a same-cycle strobe. Right shifts only
    // move the low L bits; bits above the active length hold.
    always_comb begin
        sr_d     = sr_q;
        bcnt_d   = bcnt_q;
        done_set = 1'b0;
        if (wr_shift) begin
            sr_d   = bus.reg_wdata[SH_W-1:0];
            bcnt_d = '0;
        end else if (sh) begin
            if (!dir_q) begin
                sr_d = {sr_q[SH_W-2:0], bus.shift_in};
            end else begin
                for (int i = 0; i < SH_W; i++) begin
                    if (i == int'(len_m1_q)) begin
                        sr_d[i] = bus.shift_in;
                    end else if (i < int'(len_m1_q)) begin
                        sr_d[i] = sr_shr[i];
                    end
                end
            end
            if (({1'b0, bcnt_q} + 6'd1) >= len_p1) begin
                bcnt_d   = '0;
                done_set = 1'b1;
            end else begin
                bcnt_d = bcnt_q + 5'd1;
            end
        end
        if (wr_ctrl) begin
            bcnt_d = '0;
        end
    end

    // Sticky status: a same-cycle set overrides the W1C clear.
    always_comb begin
        sts_clr     = wr_sts ? bus.reg_wdata[NCH-1:0] : '0;
        sts_ch_d    = (sts_ch_q & ~sts_clr) | ch_set;
        sts_match_d = (sts_match_q & ~(wr_sts & bus.reg_wdata[8])) | match_set;
        sts_done_d  = (sts_done_q  & ~(wr_sts & bus.reg_wdata[9])) | done_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q       <= 1'b0;
            len_m1_q    <= 5'd7;
            arl_q       <= '0;
            ien_q       <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            evt_q       <= '0;
            cmp_q       <= '0;
            sr_q        <= '0;
            bcnt_q      <= '0;
            sts_ch_q    <= '0;
            sts_match_q <= 1'b0;
            sts_done_q  <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            len_m1_q    <= len_m1_d;
            arl_q       <= arl_d;
            ien_q       <= ien_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            evt_q       <= evt_d;
            cmp_q       <= cmp_d;
            sr_q        <= sr_d;
            bcnt_q      <= bcnt_d;
            sts_ch_q    <= sts_ch_d;
            sts_match_q <= sts_match_d;
            sts_done_q  <= sts_done_d;
        end
    end

    // Register read mux
    always_comb begin
        rdata = '0;
        case (bus.reg_addr)
            3'd0: begin
                rdata[0]         = dir_q;
                rdata[12:8]      = len_m1_q;
                rdata[16 +: NCH] = arl_q;
                rdata[26:24]     = ien_q;
            end
            3'd1: begin
                rdata[NCH-1:0] = sts_ch_q;
                rdata[8]       = sts_match_q;
                rdata[9]       = sts_done_q;
            end
            3'd2: rdata[SH_W-1:0] = sr_q;
            3'd3: begin
                rdata[EVT_W-1:0]  = cmp_q;
                rdata[8 +: EVT_W] = evt_q;
            end
            default: begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (bus.reg_addr == 3'(4 + ch)) begin
                        rdata[CNT_W-1:0] = cnt_q[ch];
                    end
                end
            end
        endcase
    end

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            bus.cnt_zero[ch] = (cnt_q[ch] == '0);
        end
    end

    assign bus.reg_rdata  = rdata;
    assign bus.evt_match  = (evt_q == cmp_q);
    assign bus.shift_done = (bcnt_q == 5'd0);
    assign bus.shift_out  = dir_q ? sr_q[0] : sr_q[len_m1_q];
    assign bus.irq        = ((|sts_ch_q) & ien_q[0]) |
                            (sts_match_q & ien_q[1]) |
                            (sts_done_q  & ien_q[2]);

endmodule

// File: tb/tb_prism_aux_engine.sv
module tb_prism_aux_engine;

    localparam int NCH   = 2;
    localparam int CNT_W = 24;
    localparam int SH_W  = 32;
    localparam int EVT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prism_aux_engine_if #(.NCH(NCH)) bus ();

    prism_aux_engine #(
        .CNT_W(CNT_W), .NCH(NCH), .SH_W(SH_W), .EVT_W(EVT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural reference model ----------------
    longint unsigned m_cnt [NCH];
    longint unsigned m_pre [NCH];
    longint unsigned m_sr;
    int              m_evt, m_cmp, m_bcnt, m_len;
    bit              m_dir;
    bit [NCH-1:0]    m_arl, m_sch;
    bit [2:0]        m_ien;
    bit              m_smatch, m_sdone;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            m_pre[c] = 0;
        end
        m_sr = 0; m_evt = 0; m_cmp = 0; m_bcnt = 0; m_len = 8; m_dir = 0;
        m_arl = '0; m_sch = '0; m_ien = '0; m_smatch = 0; m_sdone = 0;
    endtask

    task automatic model_step();
        bit [NCH-1:0]    set_ch;
        bit              set_m, set_d, wr, ex;
        int              a, lf;
        longint unsigned wd, lm, srmask;
        set_ch = '0; set_m = 0; set_d = 0;
        wr = bus.reg_wr; ex = bus.exec; a = int'(bus.reg_addr); wd = 64'(bus.reg_wdata);
        srmask = (64'd1 << SH_W) - 1;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            if (ex && bus.cnt_load[c]) m_cnt[c] = m_pre[c];
            else if (ex && bus.cnt_dec[c]) begin
                if (m_cnt[c] == 1) begin
                    set_ch[c] = 1;
                    m_cnt[c] = m_arl[c] ? m_pre[c] : 0;
                end else if (m_cnt[c] > 1) m_cnt[c] = m_cnt[c] - 1;
            end
            if (wr && a == 4 + c) m_pre[c] = wd % (64'd1 << CNT_W);
        end
        if (ex && bus.evt_inc && bus.evt_clr) set_m = 1;
        else if (ex && bus.evt_inc) begin
            m_evt = (m_evt + 1) % (1 << EVT_W);
            if (m_evt == m_cmp) set_m = 1;
        end else if (ex && bus.evt_clr) m_evt = 0;
        if (wr && a == 3) m_cmp = int'(wd % (1 << EVT_W));
        if (wr && a == 2) begin
            m_sr = wd & srmask;
            m_bcnt = 0;
        end else if (ex && bus.shift) begin
            if (!m_dir) m_sr = ((m_sr << 1) | 64'(bus.shift_in)) & srmask;
            else begin
                lm = (64'd1 << m_len) - 1;
                m_sr = (m_sr & ~lm) | ((m_sr & lm) >> 1) | (64'(bus.shift_in) << (m_len - 1));
            end
            m_bcnt = m_bcnt + 1;
            if (m_bcnt == m_len) begin
                m_bcnt = 0;
                set_d = 1;
            end
        end
        if (wr && a == 1) begin
            m_sch = m_sch & ~wd[NCH-1:0];
            if (wd[8]) m_smatch = 0;
            if (wd[9]) m_sdone = 0;
        end
        m_sch = m_sch | set_ch;
        m_smatch = m_smatch | set_m;
        m_sdone = m_sdone | set_d;
        if (wr && a == 0) begin
            m_bcnt = 0;
            m_dir = wd[0];
            lf = int'(wd[12:8]);
            m_len = ((lf > SH_W - 1) ? SH_W - 1 : lf) + 1;
            m_arl = wd[16 +: NCH];
            m_ien = wd[26:24];
        end
    endtask

    function automatic logic [31:0] m_rd(input int a);
        longint unsigned v;
        v = 0;
        case (a)
            0: v = 64'(m_dir) | (64'(m_len - 1) << 8) | (64'(m_arl) << 16) | (64'(m_ien) << 24);
            1: v = 64'(m_sch) | (64'(m_smatch) << 8) | (64'(m_sdone) << 9);
            2: v = m_sr;
            3: v = 64'(m_cmp) | (64'(m_evt) << 8);
            default: if (a - 4 < NCH) v = m_cnt[a - 4];
        endcase
        return v[31:0];
    endfunction

    function automatic logic [5:0] m_out();
        logic [NCH-1:0] z;
        logic so, irq;
        for (int c = 0; c < NCH; c++) z[c] = (m_cnt[c] == 0);
        so  = m_dir ? m_sr[0] : m_sr[m_len - 1];
        irq = ((m_sch != 0) && m_ien[0]) || (m_smatch && m_ien[1]) || (m_sdone && m_ien[2]);
        return {z, (m_evt == m_cmp) ? 1'b1 : 1'b0, (m_bcnt == 0) ? 1'b1 : 1'b0, so, irq};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [5:0] dut_out();
        return {bus.cnt_zero, bus.evt_match, bus.shift_done, bus.shift_out, bus.irq};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.cnt_load = '0; bus.cnt_dec = '0; bus.evt_inc = 0; bus.evt_clr = 0;
        bus.shift = 0; bus.shift_in = 0; bus.reg_wr = 0;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        bus.reg_wr = 1; bus.reg_addr = a; bus.reg_wdata = d;
        tick();
        bus.reg_wr = 0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.reg_addr = a;
        #1;
        d = bus.reg_rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        rst = 1; idle(); bus.exec = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
        tick(); tick();
        rst = 0;
        checks++;
        if (dut_out() !== 6'b111100) begin
            errors++; $display("FAIL reset_outputs got %b want %b", dut_out(), 6'b111100);
        end
        rd(0, d); checks++;
        if (d !== 32'h0000_0700) begin
            errors++; $display("FAIL reset_ctrl got %h want %h", d, 32'h700);
        end
    endtask

    task automatic test_countdown();
        logic [31:0] d;
        reg_write(4, 3);
        bus.exec = 1; bus.cnt_load = 2'b01; tick(); bus.cnt_load = 0;
        rd(4, d); checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL cd_load got %0d want 3", d); end
        for (int k = 1; k <= 3; k++) begin
            bus.cnt_dec = 2'b01; tick(); bus.cnt_dec = 0;
            rd(4, d); checks++;
            if (d !== 32'(3 - k)) begin errors++; $display("FAIL cd_count%0d got %0d want %0d", k, d, 3 - k); end
            checks++;
            if (bus.cnt_zero[0] !== (k == 3)) begin
                errors++; $display("FAIL cd_zero%0d got %b want %b", k, bus.cnt_zero[0], k == 3);
            end
        end
        rd(1, d); checks++;
        if (d[0] !== 1'b1) begin errors++; $display("FAIL cd_status got %b want 1", d[0]); end
        reg_write(1, 32'h1);
        bus.cnt_dec = 2'b01; tick(); bus.cnt_dec = 0;
        rd(4, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL cd_hold got %0d want 0", d); end
        rd(1, d); checks++;
        if (d[0] !== 1'b0) begin errors++; $display("FAIL cd_noflag got %b want 0", d[0]); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        int exp_seq [5] = '{1, 2, 1, 2, 1};
        reg_write(1, 32'h3FF);
        reg_write(0, 32'h0101_0700);
        reg_write(4, 2);
        bus.cnt_load = 2'b01; tick(); bus.cnt_load = 0;
        rd(4, d); checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL ar_load got %0d want 2", d); end
        for (int k = 0; k < 5; k++) begin
            bus.cnt_dec = 2'b01; tick(); bus.cnt_dec = 0;
            rd(4, d); checks++;
            if (d !== 32'(exp_seq[k])) begin errors++; $display("FAIL ar_count%0d got %0d want %0d", k, d, exp_seq[k]); end
            checks++;
            if (bus.cnt_zero[0] !== 1'b0) begin errors++; $display("FAIL ar_zero%0d got 1 want 0", k); end
            if (k == 1 || k == 3) begin
                rd(1, d); checks++;
                if (d[0] !== 1'b1) begin errors++; $display("FAIL ar_status%0d got %b want 1", k, d[0]); end
                checks++;
                if (bus.irq !== 1'b1) begin errors++; $display("FAIL ar_irq%0d got %b want 1", k, bus.irq); end
                reg_write(1, 32'h1);
                checks++;
                if (bus.irq !== 1'b0) begin errors++; $display("FAIL ar_irqclr%0d got %b want 0", k, bus.irq); end
            end
        end
        // W1C racing a terminal decrement: the set must survive
        bus.reg_wr = 1; bus.reg_addr = 1; bus.reg_wdata = 32'h1; bus.cnt_dec = 2'b01;
        tick();
        bus.reg_wr = 0; bus.cnt_dec = 0;
        rd(1, d); checks++;
        if (d[0] !== 1'b1) begin errors++; $display("FAIL ar_setwins got %b want 1", d[0]); end
    endtask

    task automatic test_event();
        logic [31:0] d;
        reg_write(1, 32'h3FF);
        reg_write(0, 32'h0000_0700);
        reg_write(3, 15);
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) begin
                checks++;
                if (bus.evt_match !== 1'b0) begin errors++; $display("FAIL ev_premsatch got 1 want 0"); end
            end
            bus.evt_inc = 1; tick(); bus.evt_inc = 0;
        end
        checks++;
        if (bus.evt_match !== 1'b1) begin errors++; $display("FAIL ev_match got 0 want 1"); end
        rd(1, d); checks++;
        if (d[8] !== 1'b1) begin errors++; $display("FAIL ev_status got %b want 1", d[8]); end
        rd(3, d); checks++;
        if (d !== 32'h0F0F) begin errors++; $display("FAIL ev_read got %h want 0f0f", d); end
        bus.evt_inc = 1; tick(); bus.evt_inc = 0;
        rd(3, d); checks++;
        if (d !== 32'h000F) begin errors++; $display("FAIL ev_wrap got %h want 000f", d); end
        reg_write(1, 32'h100);
        bus.evt_inc = 1; bus.evt_clr = 1; tick(); bus.evt_inc = 0; bus.evt_clr = 0;
        rd(3, d); checks++;
        if (d !== 32'h000F) begin errors++; $display("FAIL ev_incclr_cnt got %h want 000f", d); end
        rd(1, d); checks++;
        if (d[8] !== 1'b1) begin errors++; $display("FAIL ev_incclr_flag got %b want 1", d[8]); end
        bus.evt_inc = 1; tick(); bus.evt_inc = 0;
        rd(3, d); checks++;
        if (d !== 32'h010F) begin errors++; $display("FAIL ev_inc1 got %h want 010f", d); end
        bus.evt_clr = 1; tick(); bus.evt_clr = 0;
        rd(3, d); checks++;
        if (d !== 32'h000F) begin errors++; $display("FAIL ev_clr got %h want 000f", d); end
    endtask

    task automatic test_shift_msb();
        logic [31:0] d;
        logic [7:0]  pat;
        pat = 8'hA5;
        reg_write(0, 32'h0000_0700);
        reg_write(2, 32'h0000_00A5);
        reg_write(1, 32'h3FF);
        bus.shift_in = 1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (bus.shift_out !== pat[7 - k]) begin
                errors++; $display("FAIL msb_out%0d got %b want %b", k, bus.shift_out, pat[7 - k]);
            end
            bus.shift = 1; tick(); bus.shift = 0;
            if (k == 0) begin
                checks++;
                if (bus.shift_done !== 1'b0) begin errors++; $display("FAIL msb_busy got 1 want 0"); end
            end
        end
        rd(2, d); checks++;
        if (d !== 32'h0000_A5FF) begin errors++; $display("FAIL msb_sr got %h want 0000a5ff", d); end
        rd(1, d); checks++;
        if (d[9] !== 1'b1) begin errors++; $display("FAIL msb_status got %b want 1", d[9]); end
        checks++;
        if (bus.shift_done !== 1'b1) begin errors++; $display("FAIL msb_done got 0 want 1"); end
    endtask

    task automatic test_shift_lsb();
        logic [31:0] d;
        reg_write(0, 32'h0000_1701);
        reg_write(2, 32'hAB12_3456);
        bus.shift_in = 0;
        for (int k = 0; k < 4; k++) begin
            bus.shift = 1; tick(); bus.shift = 0;
        end
        rd(2, d); checks++;
        if (d !== 32'hAB01_2345) begin errors++; $display("FAIL lsb_sr got %h want ab012345", d); end
        checks++;
        if (bus.shift_done !== 1'b0) begin errors++; $display("FAIL lsb_done got 1 want 0"); end
        checks++;
        if (bus.shift_out !== 1'b1) begin errors++; $display("FAIL lsb_out got 0 want 1"); end
        bus.reg_wr = 1; bus.reg_addr = 2; bus.reg_wdata = 32'h55; bus.shift = 1;
        tick();
        bus.reg_wr = 0; bus.shift = 0;
        rd(2, d); checks++;
        if (d !== 32'h0000_0055) begin errors++; $display("FAIL lsb_wrwins got %h want 00000055", d); end
        checks++;
        if (bus.shift_done !== 1'b1) begin errors++; $display("FAIL lsb_bcnt got 0 want 1"); end
    endtask

    task automatic test_exec_low_and_reset();
        logic [31:0] d;
        bus.exec = 0;
        bus.cnt_load = '1; bus.cnt_dec = '1; bus.evt_inc = 1; bus.evt_clr = 1;
        bus.shift = 1; bus.shift_in = 1;
        for (int k = 0; k < 10; k++) begin
            bus.reg_wr = (k == 5); bus.reg_addr = 3; bus.reg_wdata = 32'h9;
            tick();
        end
        bus.reg_wr = 0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d); checks++;
            if (d !== m_rd(a)) begin errors++; $display("FAIL ex_reg%0d got %h want %h", a, d, m_rd(a)); end
        end
        rd(3, d); checks++;
        if (d[7:0] !== 8'h09) begin errors++; $display("FAIL ex_cmpwr got %h want 09", d[7:0]); end
        rd(2, d); checks++;
        if (d !== 32'h55) begin errors++; $display("FAIL ex_srhold got %h want 55", d); end
        checks++;
        if (dut_out() !== m_out()) begin errors++; $display("FAIL ex_outs got %b want %b", dut_out(), m_out()); end
        // run with exec high, then reset mid-sequence
        bus.exec = 1; bus.evt_clr = 0; bus.cnt_load = 0;
        tick(); tick();
        rst = 1; tick(); rst = 0;
        idle();
        checks++;
        if (dut_out() !== 6'b111100) begin errors++; $display("FAIL rst_outs got %b want 111100", dut_out()); end
        rd(0, d); checks++;
        if (d !== 32'h700) begin errors++; $display("FAIL rst_ctrl got %h want 700", d); end
        rd(2, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rst_sr got %h want 0", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [2:0]  ra;
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            bus.exec     = ($urandom_range(0, 7) != 0);
            bus.cnt_load = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
            bus.cnt_dec  = NCH'($urandom);
            bus.evt_inc  = $urandom_range(0, 1);
            bus.evt_clr  = ($urandom_range(0, 7) == 0);
            bus.shift    = $urandom_range(0, 1);
            bus.shift_in = $urandom_range(0, 1);
            bus.reg_wr   = ($urandom_range(0, 5) == 0);
            bus.reg_addr = 3'($urandom_range(0, 7));
            bus.reg_wdata = $urandom;
            if (bus.reg_addr >= 3'd3) bus.reg_wdata = $urandom_range(0, 5);
            tick();
            rst = 0;
            checks++;
            if (dut_out() !== m_out()) begin
                errors++; $display("FAIL rnd_outs cyc %0d got %b want %b", n, dut_out(), m_out());
            end
            ra = 3'($urandom_range(0, 7));
            rd(ra, d); checks++;
            if (d !== m_rd(int'(ra))) begin
                errors++; $display("FAIL rnd_reg%0d cyc %0d got %h want %h", ra, n, d, m_rd(int'(ra)));
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_countdown();
        test_autoreload();
        test_event();
        test_shift_msb();
        test_shift_lsb();
        test_exec_low_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prism_aux_engine.md
# prism_aux_engine

Parametrised counter/shifter co-processor for the PRISM programmable state machine peripheral. It replaces the fixed 24-bit countdown, 4-bit event counter and 8/24-bit shifter with the following:
- `NCH` independent countdown channels with optional auto-reload.
- A configurable-length bidirectional shift register.
- Sticky W1C status flags with a maskable interrupt.

It sits between the PRISM FSM's output strobes / input conditions and the TinyQV register bus.

## Interface
- `CNT_W`, 24: countdown channel width (2..32).
- `NCH`, 2: number of countdown channels (1..4).
- `SH_W`, 32: shift register width (8..32).
- `EVT_W`, 4: event counter width (1..8).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `exec` in 1: FSM running. When low, all strobe inputs are ignored.
- `cnt_load` in NCH: per-channel load-from-preload strobe.
- `cnt_dec` in NCH: per-channel decrement strobe.
- `evt_inc`, `evt_clr` in 1 each: event counter strobes.
- `shift` in 1: shift strobe.
- `shift_in` in 1: serial data in.
- `reg_addr` in 3: register word index.
- `reg_wr` in 1: 32-bit write strobe.
- `reg_wdata` in 32: write data.
- `reg_rdata` out 32: read data, combinational from `reg_addr`.
- `cnt_zero` out NCH: channel count equals 0.
- `evt_match` out 1: event count equals compare value.
- `shift_done` out 1: shift bit counter equals 0.
- `shift_out` out 1: serial data out.
- `irq` out 1: `|(STATUS & enables)`.

## Operation
Registers (reg_addr):
- 0 CTRL:
  - [0] dir: 0 = MSB-first/left shift, 1 = LSB-first/right shift.
  - [12:8] len−1: active shift length; values ≥ SH_W clamp to SH_W−1.
  - [16+NCH−1:16] per-channel auto-reload enable.
  - [24] zero-interrupt enable.
  - [25] match-interrupt enable.
  - [26] done-interrupt enable.
- 1 STATUS, W1C:
  - [NCH−1:0] channel terminal reached.
  - [8] event match.
  - [9] shift done.
- 2 SHIFT: read/write shift register, zero-extended.
- 3 EVT: write [EVT_W−1:0] sets compare. Read returns compare in [7:0] and count in [15:8].
- 4+ch: write sets the preload for channel ch; the count is not affected. Read returns the current count. Indices ≥ 4+NCH read 0 and ignore writes.

Countdown channel ch (all actions require `exec`):
- load strobe: count ← preload. Load has priority over dec.
- dec strobe with count > 1: count − 1.
- dec strobe with count == 1: set STATUS[ch]. Count becomes preload if auto-reload is enabled, otherwise 0.
- dec strobe with count == 0: hold; no flag.

Event counter:
- inc only: count + 1, wrapping modulo 2^EVT_W. Sets STATUS[8] when the new count equals compare.
- clr only: count ← 0.
- inc and clr together: count unchanged, STATUS[8] set (FSM software event).

Shifter, with L = len:
- dir 0: sr ← {sr[SH_W−2:0], shift_in}. `shift_out` = sr[L−1].
- dir 1: sr[L−1] ← shift_in, sr[L−2:0] ← sr[L−1:1]. Bits above L−1 are held. `shift_out` = sr[0].
- Bit counter bcnt (5 bits) increments per shift. On reaching L it wraps to 0 and sets STATUS[9].

Priority and boundary rules:
- A register write to SHIFT or CTRL clears bcnt. A SHIFT write in the same cycle as a shift strobe wins; the shift is dropped.
- W1C on a STATUS bit in the same cycle that the bit is set: the set wins.
- Register writes take effect regardless of `exec`.
- Reset asserted mid-operation overrides everything in that cycle.

## Timing
- All state updates land on the `clk` edge after the strobe or write.
- `cnt_zero`, `evt_match`, `shift_done`, `shift_out` and `irq` are combinational from registered state. They are visible the cycle after the causing strobe, i.e. one-cycle latency to the FSM condition inputs.
- `reg_rdata` is combinational: zero-wait reads.
- Reset values:
  - All counts, preloads, compare, sr, bcnt, STATUS and enables are 0.
  - CTRL len−1 = 7 (8-bit shift), dir = 0.
- Outputs after reset: `cnt_zero` all 1, `evt_match` 1, `shift_done` 1, `shift_out` 0, `irq` 0.

## Test plan
- Channel countdown: preload ch0 = 3, load, then 3 decs.
  - Count goes 3→2→1→0, `cnt_zero[0]` rises the cycle after the 3rd dec, STATUS[0] = 1.
  - A 4th dec holds 0 and sets no new flag.
- Auto-reload: CTRL[16] = 1, preload 2, zero-irq enabled, 5 decs.
  - Count sequence is 2,1,2,1,2,1. STATUS[0] is set after decs 2 and 4, `irq` = 1, `cnt_zero` never asserts.
  - W1C of STATUS[0] in the same cycle as a new terminal event leaves STATUS[0] = 1.
- Event counter, EVT_W = 4, compare = 15: 15 incs.
  - `evt_match` = 1 and STATUS[8] set.
  - A 16th inc wraps the count to 0.
  - inc and clr together leave the count unchanged and set STATUS[8].
- Shift MSB-first, len 8: write SHIFT = 0xA5, shift 8 times with shift_in = 1.
  - `shift_out` sequence is 1,0,1,0,0,1,0,1.
  - sr[7:0] = 0xFF and STATUS[9] set after the 8th shift.
- Shift LSB-first, len 24: write 0x123456, shift 4 times with shift_in = 0.
  - sr = 0x012345, bits [31:24] are unchanged, `shift_done` = 0.
  - A SHIFT write in the same cycle as a strobe loads the written value and bcnt = 0.
- `exec` = 0 with all strobes high for 10 cycles: no state change.
  - Register writes still land.
  - Reset asserted mid-sequence returns every output to its reset value on the next edge.
